// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared MDU op codes, the issue request bundle and op decode helpers.
package mdu_issue_ctrl_pkg;

  localparam int OP_W = 4;
  localparam int XLEN = 32;

  localparam logic [OP_W-1:0] MDU_NONE  = 4'd0;
  localparam logic [OP_W-1:0] MDU_MULT  = 4'd1;
  localparam logic [OP_W-1:0] MDU_MULTU = 4'd2;
  localparam logic [OP_W-1:0] MDU_DIV   = 4'd3;
  localparam logic [OP_W-1:0] MDU_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MDU_MTHI  = 4'd5;
  localparam logic [OP_W-1:0] MDU_MTLO  = 4'd6;
  localparam logic [OP_W-1:0] MDU_READ  = 4'd7;

  // What the MDU sees in one cycle.
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
  } mdu_req_t;

  // Unassigned codes collapse to NONE so they never issue or stall.
  function automatic logic [OP_W-1:0] mdu_norm_op(input logic [OP_W-1:0] op);
    return (op > MDU_READ) ? MDU_NONE : op;
  endfunction

  function automatic logic mdu_is_mul(input logic [OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic mdu_is_div(input logic [OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_busy_timer.sv
// Local copy of the MDU's multi-cycle latency: holds the countdown and
// whether the in-flight op is a multiply or a divide.
module mdu_issue_ctrl_busy_timer #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             load_div,
  output logic [CNT_W-1:0] cnt,
  output logic             busy_mul,
  output logic             busy_div,
  output logic             idle
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_MUL = 2'd1,
    BUSY_DIV = 2'd2
  } state_t;

  state_t state;

  // Load on issue, count down while busy, return to IDLE on the last busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state <= load_div ? BUSY_DIV : BUSY_MUL;
            cnt   <= load_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
          end
        end
        default: begin
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign idle     = (state == IDLE);
  assign busy_mul = (state == BUSY_MUL);
  assign busy_div = (state == BUSY_DIV);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage MDU issue controller: issues each MDU op exactly once, stalls
// D/E behind an in-flight multiply/divide, and drops ops cancelled at M.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            e_i_valid,
  input  logic [OP_W-1:0] e_i_mdu_op,
  input  logic [XLEN-1:0] e_i_rs,
  input  logic [XLEN-1:0] e_i_rt,
  input  logic            m_i_flush,
  input  logic            mdu_i_busy,
  output logic [OP_W-1:0] mdu_o_op,
  output logic [XLEN-1:0] mdu_o_operand1,
  output logic [XLEN-1:0] mdu_o_operand2,
  output logic            ctl_o_stall,
  output logic            ctl_o_pending,
  output logic            ctl_o_mismatch
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);

  logic [OP_W-1:0]  op;
  logic             want;
  logic             issue;
  logic             idle;
  logic             busy_mul;
  logic             busy_div;
  logic [CNT_W-1:0] cnt;
  logic             issued_q;
  logic             mismatch_q;
  logic             mismatch_set;
  mdu_req_t         req;

  assign op   = mdu_norm_op(e_i_mdu_op);
  assign want = e_i_valid && (op != MDU_NONE);

  // A flush at M cancels the E instruction: neither issue nor stall, so
  // the pipeline is free to redirect. Reset also suppresses both.
  assign issue       = want && idle && !m_i_flush && !reset;
  assign ctl_o_stall = want && !idle && !m_i_flush && !reset;

  mdu_issue_ctrl_busy_timer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (issue && (mdu_is_mul(op) || mdu_is_div(op))),
    .load_div (mdu_is_div(op)),
    .cnt      (cnt),
    .busy_mul (busy_mul),
    .busy_div (busy_div),
    .idle     (idle)
  );

  // Present the op and operands only in the issuing cycle; NONE otherwise,
  // which also gives the MDU its NONE cycle to commit while busy.
  always_comb begin
    req = '0;
    if (issue) begin
      req.op       = op;
      req.operand1 = e_i_rs;
      req.operand2 = e_i_rt;
    end
  end

  assign mdu_o_op       = req.op;
  assign mdu_o_operand1 = req.operand1;
  assign mdu_o_operand2 = req.operand2;
  assign ctl_o_pending  = !idle;

  // MDU busy while we believe it is idle, or not busy one cycle into a
  // multi-cycle op, means the two latency models have diverged.
  assign mismatch_set =
      (idle && !issued_q && mdu_i_busy) ||
      (busy_mul && (cnt == CNT_W'(MUL_LAT - 1)) && !mdu_i_busy) ||
      (busy_div && (cnt == CNT_W'(DIV_LAT - 1)) && !mdu_i_busy);

  // Track last-cycle issue and hold the mismatch flag until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_q   <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      issued_q   <= issue;
      mismatch_q <= mismatch_q | mismatch_set;
    end
  end

  assign ctl_o_mismatch = mismatch_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Randomized + directed bench for mdu_issue_ctrl against a cycle-count model.
module tb_mdu_issue_ctrl;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_i_valid;
  logic [3:0]  e_i_mdu_op;
  logic [31:0] e_i_rs, e_i_rt;
  logic        m_i_flush;
  logic        mdu_i_busy;
  logic [3:0]  mdu_o_op;
  logic [31:0] mdu_o_operand1, mdu_o_operand2;
  logic        ctl_o_stall, ctl_o_pending, ctl_o_mismatch;

  always #5 clk = ~clk;

  mdu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .e_i_valid      (e_i_valid),
    .e_i_mdu_op     (e_i_mdu_op),
    .e_i_rs         (e_i_rs),
    .e_i_rt         (e_i_rt),
    .m_i_flush      (m_i_flush),
    .mdu_i_busy     (mdu_i_busy),
    .mdu_o_op       (mdu_o_op),
    .mdu_o_operand1 (mdu_o_operand1),
    .mdu_o_operand2 (mdu_o_operand2),
    .ctl_o_stall    (ctl_o_stall),
    .ctl_o_pending  (ctl_o_pending),
    .ctl_o_mismatch (ctl_o_mismatch)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: cycles of MDU work remaining, latency of the current op,
  // whether the previous cycle issued, and the sticky disagreement flag.
  int m_left  = 0;
  int m_lat   = 0;
  bit m_prev  = 0;
  bit m_mism  = 0;
  bit m_known = 0;

  // Outputs captured during the last cycle for directed spot checks.
  logic [3:0]  got_op;
  logic [31:0] got_a, got_b;
  logic        got_stall, got_pend, got_mism;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle. bmode: 0 = MDU busy follows a well-behaved MDU,
  // 1 = forced high, 2 = forced low.
  task automatic cyc(input bit v, input int op, input logic [31:0] rs,
                     input logic [31:0] rt, input bit fl, input int bmode,
                     input bit rst);
    bit want, ex_issue, ex_stall, mb, cond;
    reset      = rst;
    e_i_valid  = v;
    e_i_mdu_op = 4'(op);
    e_i_rs     = rs;
    e_i_rt     = rt;
    m_i_flush  = fl;
    mb = (bmode == 1) ? 1'b1 : (bmode == 2) ? 1'b0 : (m_left > 0);
    mdu_i_busy = mb;
    #1;
    want     = v && (op >= 1) && (op <= 7);
    ex_issue = want && (m_left == 0) && !fl && !rst;
    ex_stall = want && (m_left > 0) && !fl && !rst;
    got_op = mdu_o_op; got_a = mdu_o_operand1; got_b = mdu_o_operand2;
    got_stall = ctl_o_stall; got_pend = ctl_o_pending; got_mism = ctl_o_mismatch;
    if (m_known) begin
      chk("op",       32'(mdu_o_op),       ex_issue ? 32'(op) : 32'd0);
      chk("operand1", mdu_o_operand1,      ex_issue ? rs : 32'd0);
      chk("operand2", mdu_o_operand2,      ex_issue ? rt : 32'd0);
      chk("stall",    32'(ctl_o_stall),    32'(ex_stall));
      chk("pending",  32'(ctl_o_pending),  32'(m_left > 0));
      chk("mismatch", 32'(ctl_o_mismatch), 32'(m_mism));
    end
    @(posedge clk);
    if (rst) begin
      m_left = 0; m_lat = 0; m_prev = 0; m_mism = 0; m_known = 1;
    end else begin
      cond = (m_left == 0 && !m_prev && mb) ||
             (m_left > 0 && m_left == m_lat - 1 && !mb);
      if (cond) m_mism = 1;
      if (m_left > 0) m_left--;
      else if (ex_issue && (op == 1 || op == 2)) begin m_left = MUL_LAT; m_lat = MUL_LAT; end
      else if (ex_issue && (op == 3 || op == 4)) begin m_left = DIV_LAT; m_lat = DIV_LAT; end
      m_prev = ex_issue;
    end
    #1;
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rst_pending", 32'(ctl_o_pending), 0);
    chk("rst_op",      32'(mdu_o_op), 0);
    chk("rst_mism",    32'(ctl_o_mismatch), 0);

    // MULT 3 * -4, then MFHI stalls 5 cycles and issues in cycle 6.
    cyc(1, 1, 32'd3, 32'hFFFF_FFFC, 0, 0, 0);
    chk("plan_mult_op", 32'(got_op), 1);
    chk("plan_mult_a",  got_a, 32'd3);
    chk("plan_mult_b",  got_b, 32'hFFFF_FFFC);
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 7, 0, 0, 0, 0, 0);
      chk("plan_mfhi_stall", 32'(got_stall), 1);
      chk("plan_mfhi_pend",  32'(got_pend), 1);
    end
    cyc(1, 7, 0, 0, 0, 0, 0);
    chk("plan_mfhi_issue", 32'(got_op), 7);
    chk("plan_mfhi_nostall", 32'(got_stall), 0);

    // DIVU then DIV: DIV stalls 10 cycles, then issues.
    cyc(1, 4, 32'd100, 32'd7, 0, 0, 0);
    for (int i = 0; i < DIV_LAT; i++) begin
      cyc(1, 3, 32'd9, 32'd0, 0, 0, 0);
      chk("plan_div_stall", 32'(got_stall), 1);
    end
    cyc(1, 3, 32'd9, 32'd0, 0, 0, 0);
    chk("plan_div_issue", 32'(got_op), 3);
    chk("plan_div_pend_low", 32'(got_pend), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("plan_div_pend_again", 32'(got_pend), 1);
    idle_cyc(DIV_LAT);

    // MULT with flush: nothing issues, state stays idle.
    cyc(1, 1, 32'd5, 32'd6, 1, 0, 0);
    chk("plan_flush_op", 32'(got_op), 0);
    chk("plan_flush_stall", 32'(got_stall), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("plan_flush_pend", 32'(got_pend), 0);

    // MULT, then MTLO flushed in cycle 2; refetched MTLO issues in cycle 6.
    cyc(1, 1, 32'd2, 32'd2, 0, 0, 0);
    cyc(1, 6, 32'd1, 0, 0, 0, 0);
    cyc(1, 6, 32'd1, 0, 1, 0, 0);
    chk("plan_mtlo_flush_stall", 32'(got_stall), 0);
    chk("plan_mtlo_flush_op", 32'(got_op), 0);
    for (int i = 3; i <= 5; i++) begin
      cyc(1, 6, 32'd1, 0, 0, 0, 0);
      chk("plan_mtlo_stall", 32'(got_stall), 1);
    end
    cyc(1, 6, 32'd1, 0, 0, 0, 0);
    chk("plan_mtlo_issue", 32'(got_op), 6);

    // Reset in cycle 3 of a DIV; a fresh MULT issues right after.
    cyc(1, 3, 32'd8, 32'd2, 0, 0, 0);
    cyc(1, 5, 0, 0, 0, 0, 0);
    cyc(1, 5, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 32'd4, 32'd4, 0, 0, 0);
    chk("plan_rst_pend", 32'(got_pend), 0);
    chk("plan_rst_stall", 32'(got_stall), 0);
    chk("plan_rst_mult", 32'(got_op), 1);
    idle_cyc(MUL_LAT + 1);

    // Busy while idle with no prior issue: sticky mismatch until reset.
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle_cyc(3);
    chk("plan_mism_sticky", 32'(got_mism), 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("plan_mism_clear", 32'(got_mism), 0);

    // Random traffic; occasional flush, reset and MDU busy disagreement.
    for (int i = 0; i < 4000; i++) begin
      bit v, fl, rst;
      int op, bm, r;
      v   = ($urandom_range(0, 9) < 7);
      op  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 7) : $urandom_range(8, 15);
      fl  = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 299) == 0);
      r   = $urandom_range(0, 399);
      bm  = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      cyc(v, op, $urandom, $urandom, fl, bm, rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_issue_ctrl.md
# mdu_issue_ctrl

Execute-stage issue controller that drives the MDU. It decodes the E-stage instruction's MDU operation and presents it, with operands, to the MDU exactly once. It mirrors the MDU's multi-cycle latency with its own state machine and stalls D/E while a new MDU instruction would collide with an in-flight multiply or divide. It suppresses issue when an exception or interrupt is taken at M, so cancelled instructions never modify HI/LO.

## Interface
- MUL_LAT, 5, busy cycles after a MULT/MULTU issue
- DIV_LAT, 10, busy cycles after a DIV/DIVU issue
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- e_i_valid  in  1  E stage holds a live instruction
- e_i_mdu_op  in  4  decoded MDU op code of the E instruction (package codes)
- e_i_rs  in  32  forwarded rs value
- e_i_rt  in  32  forwarded rt value
- m_i_flush  in  1  exception/interrupt taken at M this cycle; E instruction is cancelled
- mdu_i_busy  in  1  busy flag from the MDU
- mdu_o_op  out  4  operation to the MDU; NONE when not issuing
- mdu_o_operand1  out  32  e_i_rs when issuing, else 0
- mdu_o_operand2  out  32  e_i_rt when issuing, else 0
- ctl_o_stall  out  1  freeze PC/D/E this cycle
- ctl_o_pending  out  1  a MULT/DIV is in flight (state != IDLE)
- ctl_o_mismatch  out  1  sticky: MDU busy disagrees with the local model

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, READ=7. Codes 8–15 are treated as NONE.
- want = e_i_valid && op != NONE.
- States:
  - IDLE: cnt = 0.
  - BUSY_MUL or BUSY_DIV: cnt in 1..LAT.
- ctl_o_stall = want && state != IDLE && !m_i_flush. Flush masks stall so the pipeline can redirect.
- issue = want && state == IDLE && !m_i_flush. Issue drives mdu_o_op = op and the operands; otherwise mdu_o_op = NONE and the operands are 0.
- mdu_o_op is forced to NONE whenever state != IDLE. This guarantees the MDU sees a NONE cycle to commit its result.
- Transitions at the posedge:
  - issue of MULT/MULTU: BUSY_MUL, cnt ← MUL_LAT.
  - issue of DIV/DIVU: BUSY_DIV, cnt ← DIV_LAT.
  - issue of MTHI/MTLO/READ: stay IDLE.
  - BUSY_x: cnt ← cnt − 1; when cnt == 1, go to IDLE.
- m_i_flush while BUSY: the in-flight op continues. It was issued by an older, committed instruction, so state and counter are unaffected.
- Divide by zero follows the same latency; the result value is the MDU's concern.
- Mismatch check: ctl_o_mismatch sets when state == IDLE, the previous cycle did not issue, and mdu_i_busy == 1. It also sets when the state is BUSY with cnt == MUL_LAT or DIV_LAT − 1 after load and mdu_i_busy == 0. It clears only on reset.
- reset (including mid-operation): state IDLE, cnt 0, mdu_o_op NONE, operands 0, stall 0, pending 0, mismatch 0.

## Timing
- Issue is combinational in the cycle the instruction sits unstalled in E; the MDU samples it at the next posedge (edge T).
- A MULT issued in cycle 0 gives cnt = 5..1 in cycles 1..5. A following MDU op (including READ for mfhi/mflo) stalls in cycles 1..5 and issues in cycle 6. DIV is the same with 10.
- Back-to-back MDU ops with state IDLE (e.g. MTHI then MFHI) issue in consecutive cycles with no stall.
- Non-MDU instructions never stall, regardless of state.
- Simultaneous want and m_i_flush: no issue, no stall, no state change.

## Structure
- Op codes and the NONE value belong in the shared macro header, with the same MDU_* defines the MDU uses. State encodings stay local.
- One natural sub-module: mdu_busy_timer (load value, load strobe, decrement, zero flag), holding cnt and the BUSY_MUL/BUSY_DIV tag.
- Top level: issue/stall logic, operand muxing, mismatch flag.

## Test plan
- MULT rs=3, rt=−4 in cycle 0, MFHI in cycle 1 → mdu_o_op=1 with operands 3 and 0xFFFFFFFC in cycle 0; stall in cycles 1–5; mdu_o_op=7 in cycle 6; pending high in cycles 1–5.
- DIVU then DIV back-to-back → second op stalls for 10 cycles, then issues with op=3; pending drops after 10 cycles, then reasserts.
- MULT with m_i_flush=1 in the same cycle → mdu_o_op=NONE, no stall, state remains IDLE, pending stays 0.
- MULT issued, m_i_flush pulsed in cycle 2 with an MTLO in E → no stall and no issue in cycle 2; MTLO refetched later still stalls until cycle 6.
- reset asserted in cycle 3 of a DIV → the next cycle has pending=0, stall=0, mdu_o_op=NONE; a new MULT issues immediately.
- mdu_i_busy forced high while IDLE with no issue → ctl_o_mismatch=1 and remains 1 until reset.
